// File: rtl/slos_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : slos_tx_gen
// Description : Serial SLOS1/SLOS2 generator. On start, emits NUM_SLOS
//               back-to-back 2048-bit PRBS11 (x^11+x^9+1) ordered sets,
//               inverted for SLOS2, then pulses slos_done.
// Revision    : 1.0 - initial release
// ============================================================================
module slos_tx_gen #(
  parameter logic [10:0] SEED     = 11'h400,
  parameter int unsigned NUM_SLOS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic start,
  input  logic slos1_slos2,
  output logic data_out,
  output logic busy,
  output logic slos_done
);

  localparam int unsigned           CNT_W       = $clog2(NUM_SLOS + 1);
  localparam logic [CNT_W-1:0]      C_LAST_SLOS = CNT_W'(NUM_SLOS - 1);
  localparam logic [10:0]           C_LAST_BIT  = 11'd2047;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_next_state;
  logic [10:0]      r_lfsr;
  logic [10:0]      r_bit_cnt;
  logic [CNT_W-1:0] r_slos_cnt;
  logic             r_type_q;
  logic             r_slos_done;
  logic             w_last_bit;
  logic             w_last_slos;
  logic             w_seq_end;

  assign w_last_bit  = (r_bit_cnt == C_LAST_BIT);
  assign w_last_slos = (r_slos_cnt == C_LAST_SLOS);
  assign w_seq_end   = (r_state == S_SEND) && enable && w_last_bit && w_last_slos;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable && start) begin
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (!enable || (w_last_bit && w_last_slos)) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: the line is forced low outside SEND so IDLE always reads 0
  always_comb begin
    busy     = (r_state == S_SEND);
    data_out = busy & (r_lfsr[0] ^ r_type_q);
  end

  assign slos_done = r_slos_done;

  // Datapath. Any transition into IDLE reloads the seed, so aborts leave a
  // clean starting point for the next request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr      <= SEED;
      r_bit_cnt   <= 11'd0;
      r_slos_cnt  <= '0;
      r_type_q    <= 1'b0;
      r_slos_done <= 1'b0;
    end else begin
      r_slos_done <= w_seq_end;
      if (w_next_state == S_IDLE) begin
        r_lfsr     <= SEED;
        r_bit_cnt  <= 11'd0;
        r_slos_cnt <= '0;
        r_type_q   <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_type_q <= slos1_slos2;
      end else begin
        r_bit_cnt <= r_bit_cnt + 11'd1;
        // Holding at bit 0 emits the seed bit twice, padding the 2047-bit
        // PRBS period to a 2048-bit SLOS.
        if (r_bit_cnt != 11'd0) begin
          r_lfsr <= {r_lfsr[9:0], r_lfsr[10] ^ r_lfsr[8]};
        end
        if (w_last_bit) begin
          r_slos_cnt <= r_slos_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slos_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_slos_tx_gen
// Description : Self-checking bench for slos_tx_gen against a PRBS11
//               recurrence model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slos_tx_gen;

  localparam logic [10:0] SEED     = 11'h400;
  localparam int          NUM_SLOS = 2;
  localparam int          SEQ_LEN  = 2048 * NUM_SLOS;
  localparam int          LIMIT    = SEQ_LEN + 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic slos1_slos2 = 1'b0;
  logic data_out;
  logic busy;
  logic slos_done;

  int n_checks = 0;
  int n_pass   = 0;

  bit pat [0:2047];
  bit cap [0:LIMIT];

  slos_tx_gen #(.SEED(SEED), .NUM_SLOS(NUM_SLOS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .slos1_slos2(slos1_slos2), .data_out(data_out), .busy(busy),
    .slos_done(slos_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached (got hang, need finish)");
    $fatal(1);
  end

  // u_n = u_{n-11} ^ u_{n-9}; SLOS = u_0, u_0, u_1 .. u_2046
  task automatic build_model();
    bit u [0:2056];
    logic [10:0] s;
    s = SEED;
    for (int k = 0; k <= 10; k++) u[10 - k] = s[k];
    for (int n = 1; n <= 2046; n++) u[n + 10] = u[n - 1] ^ u[n + 1];
    pat[0] = u[10];
    for (int j = 1; j < 2048; j++) pat[j] = u[10 + j - 1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit typ);
    start = 1'b1;
    slos1_slos2 = typ;
    tick();
    start = 1'b0;
  endtask

  // Walk the busy window, recording bits and comparing to the model stream
  task automatic collect(input bit typ, input bit toggle, output int len,
                         output int nerr, output int first_bad, output int done_seen);
    len = 0; nerr = 0; first_bad = -1; done_seen = 0;
    while (busy === 1'b1 && len < LIMIT) begin
      cap[len] = data_out;
      if (data_out !== (pat[len % 2048] ^ typ)) begin
        if (nerr == 0) first_bad = len;
        nerr++;
      end
      if (slos_done !== 1'b0) done_seen++;
      if (toggle) begin
        slos1_slos2 = 1'($urandom);
        start = 1'($urandom);
      end
      len++;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    #3;
    n_checks++;
    if ({data_out, busy, slos_done} !== 3'b000)
      $display("FAIL reset_outputs: got %b need 000", {data_out, busy, slos_done});
    else n_pass++;
    tick();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({data_out, busy, slos_done} !== 3'b000) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL idle_quiet: got %0d nonzero cycles need 0", bad);
    else n_pass++;
  endtask

  task automatic test_slos1();
    int len, nerr, fb, ds;
    logic [11:0] got;
    do_start(1'b0);
    collect(1'b0, 1'b0, len, nerr, fb, ds);
    n_checks++;
    if (len != SEQ_LEN) $display("FAIL slos1_len: got %0d need %0d", len, SEQ_LEN);
    else n_pass++;
    n_checks++;
    if (nerr != 0) $display("FAIL slos1_stream: got %0d bad bits (first %0d) need 0", nerr, fb);
    else n_pass++;
    for (int i = 0; i < 12; i++) got[11 - i] = cap[i];
    n_checks++;
    if (got !== 12'b0010_0000_0001) $display("FAIL slos1_first12: got %b need 001000000001", got);
    else n_pass++;
    for (int i = 0; i < 12; i++) got[11 - i] = cap[2048 + i];
    n_checks++;
    if (got !== 12'b0010_0000_0001) $display("FAIL slos1_second12: got %b need 001000000001", got);
    else n_pass++;
    n_checks++;
    if (ds != 0) $display("FAIL slos1_early_done: got %0d need 0", ds);
    else n_pass++;
    n_checks++;
    if ({slos_done, busy, data_out} !== 3'b100)
      $display("FAIL slos1_done: got done,busy,data %b need 100", {slos_done, busy, data_out});
    else n_pass++;
    tick();
    n_checks++;
    if (slos_done !== 1'b0) $display("FAIL slos1_done_width: got %b need 0", slos_done);
    else n_pass++;
  endtask

  task automatic test_slos2();
    int len, nerr, fb, ds;
    logic [11:0] got;
    do_start(1'b1);
    collect(1'b1, 1'b0, len, nerr, fb, ds);
    for (int i = 0; i < 12; i++) got[11 - i] = cap[i];
    n_checks++;
    if (got !== 12'b1101_1111_1110) $display("FAIL slos2_first12: got %b need 110111111110", got);
    else n_pass++;
    n_checks++;
    if (len != SEQ_LEN || nerr != 0)
      $display("FAIL slos2_stream: got len %0d err %0d need len %0d err 0", len, nerr, SEQ_LEN);
    else n_pass++;
    n_checks++;
    if (slos_done !== 1'b1) $display("FAIL slos2_done: got %b need 1", slos_done);
    else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    int k, len, nerr, fb, ds, bad, dn;
    bit typ;
    typ = 1'($urandom);
    k = 990 + int'($urandom_range(0, 20));
    do_start(typ);
    bad = 0;
    for (int i = 0; i < k; i++) begin
      if (data_out !== (pat[i] ^ typ) || busy !== 1'b1) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort_prefix: got %0d bad bits need 0", bad);
    else n_pass++;
    enable = 1'b0;
    tick();
    n_checks++;
    if ({busy, data_out} !== 2'b00) $display("FAIL abort_idle: got busy,data %b need 00", {busy, data_out});
    else n_pass++;
    dn = 0; bad = 0;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (slos_done !== 1'b0) dn++;
      if (busy !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (dn != 0) $display("FAIL abort_no_done: got %0d done cycles need 0", dn);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL disabled_start: got %0d busy cycles need 0", bad);
    else n_pass++;
    typ = 1'($urandom);
    enable = 1'b1;
    do_start(typ);
    collect(typ, 1'b0, len, nerr, fb, ds);
    n_checks++;
    if (len != SEQ_LEN || nerr != 0)
      $display("FAIL abort_restart: got len %0d err %0d (first %0d) need len %0d err 0", len, nerr, fb, SEQ_LEN);
    else n_pass++;
    tick();
  endtask

  task automatic test_ignore();
    int len, nerr, fb, ds;
    bit typ;
    typ = 1'($urandom);
    do_start(typ);
    collect(typ, 1'b1, len, nerr, fb, ds);
    n_checks++;
    if (len != SEQ_LEN) $display("FAIL ignore_len: got %0d need %0d", len, SEQ_LEN);
    else n_pass++;
    n_checks++;
    if (nerr != 0) $display("FAIL ignore_stream: got %0d bad bits (first %0d) need 0", nerr, fb);
    else n_pass++;
    n_checks++;
    if (slos_done !== 1'b1) $display("FAIL ignore_done: got %b need 1", slos_done);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int len, nerr, fb, ds;
    bit typ;
    typ = 1'($urandom);
    do_start(typ);
    collect(typ, 1'b0, len, nerr, fb, ds);
    n_checks++;
    if ({slos_done, busy, data_out} !== 3'b100)
      $display("FAIL b2b_gap: got done,busy,data %b need 100", {slos_done, busy, data_out});
    else n_pass++;
    typ = 1'($urandom);
    do_start(typ);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy %b need 1", busy);
    else n_pass++;
    collect(typ, 1'b0, len, nerr, fb, ds);
    n_checks++;
    if (len != SEQ_LEN || nerr != 0)
      $display("FAIL b2b_stream: got len %0d err %0d need len %0d err 0", len, nerr, SEQ_LEN);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    int len, nerr, fb, ds;
    do_start(1'b1);
    for (int i = 0; i < 500; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({data_out, busy, slos_done} !== 3'b000)
      $display("FAIL async_reset: got data,busy,done %b need 000", {data_out, busy, slos_done});
    else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({data_out, busy, slos_done} !== 3'b000)
      $display("FAIL post_reset_idle: got %b need 000", {data_out, busy, slos_done});
    else n_pass++;
    do_start(1'b0);
    collect(1'b0, 1'b0, len, nerr, fb, ds);
    n_checks++;
    if (len != SEQ_LEN || nerr != 0)
      $display("FAIL post_reset_stream: got len %0d err %0d (first %0d) need len %0d err 0", len, nerr, fb, SEQ_LEN);
    else n_pass++;
    tick();
  endtask

  initial begin
    build_model();
    test_reset();
    test_slos1();
    test_slos2();
    test_abort();
    test_ignore();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
